// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the load/data write port of the datapath registers.
// One request is granted per cycle; the load enable and data are registered one cycle later.
module reg_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int NUM_REG = 3,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        stall_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REG-1:0]          load_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        err_o,
    output logic [$clog2(NUM_REQ)-1:0]  rr_ptr_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [NUM_REG-1:0] load_reg;
    logic [DATA_W-1:0]  data_reg;
    logic               err_reg;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               found;
    logic [PTR_W:0]     search_sum;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W:0]     ptr_sum;
    logic [PTR_W-1:0]   rr_ptr_next;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               addr_oor;
    logic [NUM_REG-1:0] load_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Rotating priority search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        found      = 1'b0;
        search_sum = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            search_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
            if (search_sum >= (PTR_W+1)'(NUM_REQ))
                search_sum = search_sum - (PTR_W+1)'(NUM_REQ);
            cand = search_sum[PTR_W-1:0];
            if (!found && req_valid_i[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found && !stall_i && !rst_i)
            grant[grant_idx] = 1'b1;
    end

    assign transfer = |grant;
    assign sel_addr = addr_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];
    assign addr_oor = sel_addr >= ADDR_W'(NUM_REG);

    always_comb begin
        ptr_sum = {1'b0, grant_idx} + (PTR_W+1)'(1);
        if (ptr_sum >= (PTR_W+1)'(NUM_REQ))
            ptr_sum = '0;
        rr_ptr_next = ptr_sum[PTR_W-1:0];
    end

    // Out-of-range indices match no decoder bit, so the write is dropped.
    generate
        for (gi = 0; gi < NUM_REG; gi++) begin : g_load_dec
            assign load_next[gi] = transfer && (sel_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_reg   <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
            rr_ptr_reg <= '0;
        end else begin
            load_reg <= load_next;
            err_reg  <= transfer && addr_oor;
            if (transfer) begin
                data_reg   <= sel_data;
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign req_ready_o = grant;
    assign load_o      = load_reg;
    assign data_o      = data_reg;
    assign err_o       = err_reg;
    assign rr_ptr_o    = rr_ptr_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_reg_write_arbiter;

    localparam int N  = 3;
    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  valid;
    logic [1:0]  addr [N];
    logic [7:0]  wdata [N];
    logic [5:0]  req_addr;
    logic [23:0] req_data;
    logic [2:0]  ready;
    logic [2:0]  load;
    logic [7:0]  data;
    logic        err;
    logic [1:0]  rr_ptr;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state
    int         m_ptr  = 0;
    logic [2:0] m_load = '0;
    logic [7:0] m_data = '0;
    logic       m_err  = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int k = 0; k < N; k++) begin
            req_addr[k*2 +: 2] = addr[k];
            req_data[k*8 +: 8] = wdata[k];
        end
    end

    reg_write_arbiter #(.NUM_REQ(N), .NUM_REG(NR), .DATA_W(8), .ADDR_W(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .req_valid_i (valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (ready),
        .load_o      (load),
        .data_o      (data),
        .err_o       (err),
        .rr_ptr_o    (rr_ptr)
    );

    function automatic int model_winner();
        if (rst || stall) return -1;
        for (int i = 0; i < N; i++) begin
            if (valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_grant();
        int w;
        w = model_winner();
        return (w < 0) ? 3'b000 : 3'(1 << w);
    endfunction

    // Advance one clock edge and update the model from inputs seen before the edge.
    task automatic tick();
        int w;
        w = model_winner();
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_load = '0; m_data = '0; m_err = 1'b0;
        end else if (w >= 0) begin
            m_ptr  = (w + 1) % N;
            m_data = wdata[w];
            if (int'(addr[w]) < NR) begin
                m_load = 3'(1 << addr[w]);
                m_err  = 1'b0;
            end else begin
                m_load = '0;
                m_err  = 1'b1;
            end
            $display("xfer req=%0d addr=%0d data=%h", w, addr[w], wdata[w]);
        end else begin
            m_load = '0;
            m_err  = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0;
        valid = '0;
        for (int k = 0; k < N; k++) begin addr[k] = '0; wdata[k] = '0; end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        valid = 3'b111;
        tick();
        #1;
        vectors++;
        if (ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready got=%b want=000", ready); end
        tick();
        rst = 1'b0;
        valid = '0;
        tick();
        vectors++;
        if (load !== 3'b000) begin miscompares++; $display("FAIL reset_load got=%b want=000", load); end
        vectors++;
        if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h want=00", data); end
        vectors++;
        if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL reset_ptr got=%0d want=0", rr_ptr); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b want=0", err); end
    endtask

    task automatic test_single_write();
        valid = 3'b001; addr[0] = 2'd1; wdata[0] = 8'hA5;
        #1;
        vectors++;
        if (ready !== 3'b001) begin miscompares++; $display("FAIL single_ready got=%b want=001", ready); end
        tick();
        valid = '0;
        vectors++;
        if (load !== 3'b010) begin miscompares++; $display("FAIL single_load got=%b want=010", load); end
        vectors++;
        if (data !== 8'hA5) begin miscompares++; $display("FAIL single_data got=%h want=a5", data); end
        tick();
        vectors++;
        if (load !== 3'b000) begin miscompares++; $display("FAIL single_load_clear got=%b want=000", load); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        valid = 3'b111;
        addr[0] = 2'd0; addr[1] = 2'd1; addr[2] = 2'd2;
        wdata[0] = 8'h10; wdata[1] = 8'h20; wdata[2] = 8'h30;
        for (int c = 0; c < 6; c++) begin
            #1;
            vectors++;
            if (ready !== 3'(1 << (c % 3))) begin
                miscompares++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", c, ready, 3'(1 << (c % 3)));
            end
            tick();
            vectors++;
            if (load !== 3'(1 << (c % 3))) begin
                miscompares++; $display("FAIL rr_load cyc=%0d got=%b want=%b", c, load, 3'(1 << (c % 3)));
            end
            vectors++;
            if (data !== 8'(8'h10 * ((c % 3) + 1))) begin
                miscompares++; $display("FAIL rr_data cyc=%0d got=%h want=%h", c, data, 8'(8'h10 * ((c % 3) + 1)));
            end
            vectors++;
            if (rr_ptr !== 2'((c + 1) % 3)) begin
                miscompares++; $display("FAIL rr_ptr cyc=%0d got=%0d want=%0d", c, rr_ptr, (c + 1) % 3);
            end
        end
        valid = '0;
        tick();
    endtask

    task automatic test_stall();
        valid = 3'b001; tick();
        valid = 3'b010; tick();
        vectors++;
        if (rr_ptr !== 2'd2) begin miscompares++; $display("FAIL stall_setup_ptr got=%0d want=2", rr_ptr); end
        valid = 3'b110;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (ready !== 3'b000) begin miscompares++; $display("FAIL stall_ready cyc=%0d got=%b want=000", c, ready); end
            tick();
            vectors++;
            if (rr_ptr !== 2'd2) begin miscompares++; $display("FAIL stall_ptr cyc=%0d got=%0d want=2", c, rr_ptr); end
            vectors++;
            if (load !== 3'b000) begin miscompares++; $display("FAIL stall_load cyc=%0d got=%b want=000", c, load); end
        end
        stall = 1'b0;
        #1;
        vectors++;
        if (ready !== 3'b100) begin miscompares++; $display("FAIL stall_release_ready got=%b want=100", ready); end
        tick();
        vectors++;
        if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL stall_release_ptr got=%0d want=0", rr_ptr); end
        valid = '0;
        tick();
    endtask

    task automatic test_out_of_range();
        valid = 3'b010; addr[1] = 2'd3; wdata[1] = 8'hFF;
        #1;
        vectors++;
        if (ready !== 3'b010) begin miscompares++; $display("FAIL oor_ready got=%b want=010", ready); end
        tick();
        valid = '0;
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL oor_err got=%b want=1", err); end
        vectors++;
        if (load !== 3'b000) begin miscompares++; $display("FAIL oor_load got=%b want=000", load); end
        vectors++;
        if (data !== 8'hFF) begin miscompares++; $display("FAIL oor_data got=%h want=ff", data); end
        tick();
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL oor_err_clear got=%b want=0", err); end
    endtask

    task automatic test_reset_mid();
        valid = 3'b001; addr[0] = 2'd2; wdata[0] = 8'h5C;
        rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 3'b000) begin miscompares++; $display("FAIL rstmid_ready got=%b want=000", ready); end
        tick();
        rst = 1'b0;
        valid = '0;
        vectors++;
        if (load !== 3'b000) begin miscompares++; $display("FAIL rstmid_load got=%b want=000", load); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL rstmid_err got=%b want=0", err); end
        vectors++;
        if (rr_ptr !== 2'd0) begin miscompares++; $display("FAIL rstmid_ptr got=%0d want=0", rr_ptr); end
    endtask

    task automatic test_random();
        logic [2:0] exp_ready;
        for (int c = 0; c < 300; c++) begin
            rst   = ($urandom_range(0, 31) == 0);
            stall = ($urandom_range(0, 3) == 0);
            valid = 3'($urandom_range(0, 7));
            for (int k = 0; k < N; k++) begin
                addr[k]  = 2'($urandom_range(0, 3));
                wdata[k] = 8'($urandom_range(0, 255));
            end
            #1;
            exp_ready = model_grant();
            vectors++;
            if (ready !== exp_ready) begin
                miscompares++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, ready, exp_ready);
            end
            tick();
            vectors++;
            if (load !== m_load) begin miscompares++; $display("FAIL rand_load cyc=%0d got=%b want=%b", c, load, m_load); end
            vectors++;
            if (data !== m_data) begin miscompares++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, data, m_data); end
            vectors++;
            if (err !== m_err) begin miscompares++; $display("FAIL rand_err cyc=%0d got=%b want=%b", c, err, m_err); end
            vectors++;
            if (int'(rr_ptr) !== m_ptr) begin
                miscompares++; $display("FAIL rand_ptr cyc=%0d got=%0d want=%0d", c, rr_ptr, m_ptr);
            end
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_stall();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
